// File: rtl/div_sequencer_pkg.sv
// Shared types and widths for the EX-stage divide sequencer.
package div_sequencer_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESULT_W = 2 * DATA_W;

    localparam logic [DATA_W-1:0] DIVZERO_LO_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } divseq_state_e;

endpackage

// File: rtl/div_sequencer.sv
// Controls the iterative divider for DIV/DIVU: latches operands, runs the
// start/annul handshake, stalls the front of the pipe and issues one HI/LO write.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 64,
    parameter int unsigned       CNT_W          = 7,
    parameter logic [DATA_W-1:0] DIVZERO_LO     = DIVZERO_LO_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_signed,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    input  logic                flush,
    input  logic                hold,
    input  logic                div_ready,
    input  logic [RESULT_W-1:0] div_result,
    output logic                div_start,
    output logic                div_annul,
    output logic                div_signed,
    output logic [DATA_W-1:0]   div_a,
    output logic [DATA_W-1:0]   div_b,
    output logic                stall_div,
    output logic                hilo_we,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                err_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    divseq_state_e     state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic start_c, annul_c, stall_c, we_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start_c = 1'b0;
        annul_c = 1'b0;
        stall_c = 1'b0;
        we_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    stall_c = 1'b1;
                    a_d     = opa;
                    b_d     = opb;
                    sgn_d   = req_signed;
                    // A zero divisor is resolved here; the divider never sees it.
                    if (opb == '0) begin
                        hi_d    = opa;
                        lo_d    = DIVZERO_LO;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                start_c = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (flush) begin
                    annul_c = !div_ready;
                    state_d = ST_IDLE;
                end else if (div_ready) begin
                    hi_d    = div_result[RESULT_W-1:DATA_W];
                    lo_d    = div_result[DATA_W-1:0];
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    annul_c = 1'b1;
                    err_d   = 1'b1;
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    we_c    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Every output reads as zero while reset is held low.
    assign div_start   = rst & start_c;
    assign div_annul   = rst & annul_c;
    assign stall_div   = rst & stall_c;
    assign hilo_we     = rst & we_c;
    assign div_signed  = rst & sgn_q;
    assign err_timeout = rst & err_q;
    assign div_a       = rst ? a_q  : '0;
    assign div_b       = rst ? b_q  : '0;
    assign hi_o        = rst ? hi_q : '0;
    assign lo_o        = rst ? lo_q : '0;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: table of divides plus hand-written
// flush, hold, reset and sticky-timeout sequences.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_signed, flush, hold, div_ready;
    logic [31:0] opa, opb;
    logic [63:0] div_result;
    logic        div_start, div_annul, div_signed, stall_div, hilo_we, err_timeout;
    logic [31:0] div_a, div_b, hi_o, lo_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          n_ready;    // RUN cycle on which the divider is ready; 0 = never
        logic [63:0] res;
        logic        fwd;        // disturb opa/opb mid-RUN
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
        int          exp_start;
        int          exp_annul;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_signed (req_signed),
        .opa        (opa),
        .opb        (opb),
        .flush      (flush),
        .hold       (hold),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_start  (div_start),
        .div_annul  (div_annul),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .stall_div  (stall_div),
        .hilo_we    (hilo_we),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_div(input vec_t v, input string tag, input logic exp_err);
        int          stall_cnt = 0, start_cnt = 0, annul_cnt = 0, we_cnt = 0;
        int          opnd_bad = 0, post = 0;
        logic [31:0] got_hi = '0, got_lo = '0;
        logic        seen_we = 1'b0;
        div_result = v.res;
        flush      = 1'b0;
        hold       = 1'b0;
        for (int cyc = 0; cyc < 200 && post < 2; cyc++) begin
            @(negedge clk);
            req_valid  = !seen_we;
            req_signed = v.sgn;
            if (cyc == 0) begin
                opa = v.a;
                opb = v.b;
            end
            if (v.fwd && start_cnt == 10) begin
                opa = 32'h1111_1111;
                opb = 32'h0000_0005;
            end
            div_ready = (v.n_ready != 0) && (start_cnt == v.n_ready - 1);
            #1;
            if (stall_div) stall_cnt++;
            if (div_start) begin
                start_cnt++;
                if (div_a !== v.a || div_b !== v.b || div_signed !== v.sgn) opnd_bad++;
            end
            if (div_annul) annul_cnt++;
            if (seen_we) post++;
            if (hilo_we) begin
                we_cnt++;
                got_hi  = hi_o;
                got_lo  = lo_o;
                seen_we = 1'b1;
            end
        end
        req_valid = 1'b0;
        div_ready = 1'b0;
        check({tag, " stall"},   64'(stall_cnt), 64'(v.exp_stall));
        check({tag, " start"},   64'(start_cnt), 64'(v.exp_start));
        check({tag, " annul"},   64'(annul_cnt), 64'(v.exp_annul));
        check({tag, " writes"},  64'(we_cnt),    64'd1);
        check({tag, " hi"},      64'(got_hi),    64'(v.exp_hi));
        check({tag, " lo"},      64'(got_lo),    64'(v.exp_lo));
        check({tag, " operand"}, 64'(opnd_bad),  64'd0);
        check({tag, " err"},     64'(err_timeout), 64'(exp_err));
    endtask

    initial begin
        int we_cnt;
        int annul_cnt;

        //             sgn   a             b             n   res                       fwd   hi            lo            st  run an
        tbl[0] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, 0};
        tbl[1] = '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 33, 64'h0000_0001_7FFF_FFFC, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC, 34, 33, 0};
        tbl[2] = '{1'b0, 32'h1234_5678, 32'h0000_0000,  0, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF,  1,  0, 0};
        tbl[3] = '{1'b0, 32'd100,       32'd7,           1, 64'h0000_0002_0000_000E, 1'b0, 32'h0000_0002, 32'h0000_000E,  2,  1, 0};
        tbl[4] = '{1'b0, 32'h8000_0000, 32'h8000_0001,  5, 64'h8000_0000_0000_0000, 1'b0, 32'h8000_0000, 32'h0000_0000,  6,  5, 0};
        tbl[5] = '{1'b0, 32'd9,         32'd3,           0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 32'h0000_0000, 32'h0000_0000, 65, 64, 1};

        // Reset: outputs zero even with a request pending.
        rst = 1'b0; req_valid = 1'b1; req_signed = 1'b1; opa = 32'h5; opb = 32'h3;
        flush = 1'b0; hold = 1'b0; div_ready = 1'b1; div_result = 64'hFFFF;
        repeat (3) @(negedge clk);
        #1;
        check("reset outs", 64'(|{div_start, div_annul, div_signed, stall_div, hilo_we,
                                   err_timeout, div_a, div_b, hi_o, lo_o}), 64'd0);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; div_ready = 1'b0;
        #1;
        check("post-reset idle", 64'(|{div_start, stall_div, hilo_we, div_a, hi_o, lo_o}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_div(tbl[i], $sformatf("vec%0d", i), (i == 5));
        end

        // Flush seen in IDLE drops the request.
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b0; opa = 32'd50; opb = 32'd3; flush = 1'b1;
        #1;
        check("idle flush stall", 64'(stall_div), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        check("idle flush start", 64'(div_start), 64'd0);

        // Flush on the 5th RUN cycle.
        annul_cnt = 0; we_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            flush = (c == 5);
            #1;
            if (div_annul) annul_cnt++;
        end
        check("flush annul now", 64'(div_annul), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            flush = 1'b0; req_valid = 1'b0;
            #1;
            if (c == 0) check("flush to idle", 64'({stall_div, div_start}), 64'd0);
            if (div_annul) annul_cnt++;
            if (hilo_we) we_cnt++;
        end
        check("flush annul pulses", 64'(annul_cnt), 64'd1);
        check("flush no write", 64'(we_cnt), 64'd0);
        do_div(tbl[3], "after flush", 1'b1);

        // Hold in DONE for three cycles.
        we_cnt = 0;
        div_result = tbl[3].res;
        @(negedge clk);
        req_valid = 1'b1; req_signed = 1'b0; opa = 32'd100; opb = 32'd7; div_ready = 1'b1;
        @(negedge clk);
        hold = 1'b1;
        #1;
        check("hold run start", 64'(div_start), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            div_ready = 1'b0;
            #1;
            if (hilo_we) we_cnt++;
        end
        check("hold no write", 64'(we_cnt), 64'd0);
        check("hold result stable", 64'({hi_o, lo_o}), 64'h0000_0002_0000_000E);
        @(negedge clk);
        hold = 1'b0;
        #1;
        check("hold release write", 64'(hilo_we), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("hold single write", 64'(hilo_we), 64'd0);
        check("timeout sticky", 64'(err_timeout), 64'd1);

        // Reset asserted mid-RUN.
        @(negedge clk);
        req_valid = 1'b1; opa = 32'd77; opb = 32'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst in run outs", 64'(|{div_start, div_annul, div_signed, stall_div, hilo_we,
                                        err_timeout, div_a, div_b, hi_o, lo_o}), 64'd0);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("rst cleared regs", 64'(|{div_start, stall_div, err_timeout, div_a, div_b, hi_o, lo_o}), 64'd0);

        do_div(tbl[0], "after reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller for the iterative divider used by DIV/DIVU in EX.
- Latches the dividend, divisor and signedness once, then drives the divider's start/annul handshake.
- Generates the pipeline stall and issues exactly one HI/LO write per committed divide.
- Handles divide-by-zero, pipeline flush, downstream hold and a watchdog timeout.
- Instantiated beside the divider in the EX stage.

Parameters:
- TIMEOUT_CYCLES, 64: RUN cycles allowed without div_ready before abort.
- CNT_W, 7: width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- DIVZERO_LO, 32'hFFFFFFFF: LO value written on divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  EX holds a DIV or DIVU instruction.
- req_signed  in  1  1 = DIV, 0 = DIVU.
- opa  in  32  dividend (rs).
- opb  in  32  divisor (rt).
- flush  in  1  exception or flush; kills the in-flight divide.
- hold  in  1  downstream stall; EX must not retire.
- div_ready  in  1  divider done.
- div_result  in  64  divider output: {remainder, quotient}.
- div_start  out  1  start/continue to the divider.
- div_annul  out  1  abort pulse to the divider.
- div_signed  out  1  latched signedness.
- div_a  out  32  latched dividend.
- div_b  out  32  latched divisor.
- stall_div  out  1  freeze IF/ID/EX.
- hilo_we  out  1  HI/LO write strobe.
- hi_o  out  32  remainder to be written to HI.
- lo_o  out  32  quotient to be written to LO.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: when rst==0 at a clk edge, the block returns to IDLE.
  - Cleared to 0: operand regs, result regs, counter, err_timeout.
  - While rst==0, all outputs are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - stall_div = req_valid & ~flush.
  - On req_valid & ~flush: latch opa/opb/req_signed.
    - opb==0: result = {opa, DIVZERO_LO}; go to DONE; divider untouched.
    - Otherwise: go to RUN; counter := 0.
  - flush in IDLE: request ignored.
- RUN:
  - Outputs: div_start=1, stall_div=1.
  - div_a/div_b/div_signed are driven only from the latched regs; later changes on opa/opb (forwarding) have no effect.
  - Counter increments every cycle.
  - Priority order each cycle:
    1. flush & ~div_ready: div_annul=1 for this cycle; go to IDLE; no write.
    2. flush & div_ready: go to IDLE; no write; no annul.
    3. div_ready: capture div_result into hi/lo regs; go to DONE.
    4. Counter == TIMEOUT_CYCLES-1: div_annul=1; err_timeout:=1; result := 0; go to DONE.
- DONE:
  - Outputs: stall_div=0, div_start=0.
  - hilo_we = ~hold & ~flush.
  - Transitions:
    - flush: go to IDLE; no write.
    - hold: stay in DONE; result stays stable.
    - Otherwise: assert hilo_we for exactly one cycle, then go to IDLE.
  - req_valid seen in DONE never re-triggers a divide.
- hi_o/lo_o are valid whenever hilo_we=1; otherwise they hold their last value.
- Latency:
  - Divide-by-zero: stall 1 cycle; hilo_we on cycle 1.
  - Normal: stall = 1 + N RUN cycles, where N = cycles until div_ready; hilo_we on the cycle after div_ready.
- Back-to-back divides: a second request can be accepted in the IDLE cycle right after the DONE write.
- err_timeout: cleared only by reset.
- Unsigned divide with opb[31]=1 is legal; the block treats it like any other nonzero divisor.

Decomposition:
- defines.vh: DIVSEQ_IDLE/RUN/DONE 2-bit state encodings and DIVZERO_LO default; reuse the existing DIV_CONTROL/DIVU_CONTROL codes.
- The ALU decodes req_valid/req_signed from alucontrol.
- No sub-module: one state register, counter, and operand/result regs. The divider stays a sibling instance.

Test Plan:
- Signed: opa=-7 (0xFFFFFFF9), opb=2, req_signed=1, model divider ready after 33 cycles.
  - Required: stall_div high 34 cycles; one hilo_we with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
- Unsigned with forwarding change: opa=0xFFFFFFF9, opb=2, req_signed=0; change opa/opb mid-RUN.
  - Required: div_a/div_b unchanged; lo_o=0x7FFFFFFC, hi_o=1.
- Divide-by-zero: opa=0x12345678, opb=0.
  - Required: div_start never high; stall_div 1 cycle; hi_o=0x12345678, lo_o=0xFFFFFFFF.
- Flush 5 cycles into RUN.
  - Required: div_annul pulses 1 cycle; state IDLE; no hilo_we; next request proceeds normally.
- Hold in DONE for 3 cycles, and separately rst=0 in RUN.
  - Hold required: hilo_we only on the first cycle with hold=0; exactly one write.
  - Reset required: next cycle all outputs 0, state IDLE.
- Timeout: divider never asserts ready.
  - Required: after 64 RUN cycles, div_annul pulses 1 cycle; err_timeout=1 (sticky); hilo_we writes hi_o=lo_o=0.
